bw_clk_gclk_center_seq: RTL and testbench
=========================================

BW_CLK_GCLK_CENTER_SEQ -- requirements
Module: bw_clk_gclk_center_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-002 gclk  input  1  global clock; all state updates on its rising edge.
REQ-003 grst  input  1  reset, asynchronous assert, active-high.
REQ-004 start_req  input  1  level request to bring up the cmp/ddr/jbus clock branches.
REQ-005 stop_req  input  1  level request to shut down the branches.
REQ-006 settle  input  4  inter-stage settle count S, 0..15.
REQ-007 ratio  input  4  jbus sync period P; values 0 and 1 SHALL be treated as 2.
REQ-008 cmp_en  output  1  enable for the cmp branch inverter driver.
REQ-009 ddr_en  output  1  enable for the ddr branch inverter driver.
REQ-010 jbus_en  output  1  enable for the jbus branch inverter driver.
REQ-011 seq_busy  output  1  a sequence is in progress.
REQ-012 seq_done  output  1  one-cycle pulse when a bring-up or shutdown completes.
REQ-013 jbus_sync  output  1  one-cycle cmp-to-jbus ratio sync pulse.

Function
REQ-014 The block SHALL implement the states OFF, UP1, UP2, ON, DN1 and DN2.
REQ-015 OFF with start_req=1: set cmp_en=1, latch settle into S_reg and ratio into P_reg, load cnt=S, go to UP1.
REQ-016 UP1:
- cnt!=0: decrement cnt.
- cnt==0: set ddr_en=1, load cnt=S_reg, go to UP2.
REQ-017 UP2 with cnt==0: set jbus_en=1 and seq_done=1 (registered, same edge), go to ON; otherwise decrement cnt.
REQ-018 Consecutive enables SHALL rise S+1 cycles apart; S=0 gives a 1-cycle spacing.
REQ-019 ON with stop_req=1 or stop_pend=1:
- clear jbus_en and stop_pend;
- latch settle into S_reg;
- load cnt=S;
- go to DN1.
REQ-020 DN1 with cnt==0: clear ddr_en, load cnt=S_reg, go to DN2; otherwise decrement cnt.
REQ-021 DN2 with cnt==0: clear cmp_en, pulse seq_done, go to OFF; otherwise decrement cnt.
REQ-022 Enables SHALL fall in reverse order (jbus, ddr, cmp), spaced S+1 cycles apart.
REQ-023 stop_req=1 in UP1 or UP2 SHALL set stop_pend; bring-up completes, then ON exits to DN1 on the following edge regardless of stop_req.
REQ-024 start_req SHALL be ignored in UP1, UP2, DN1, DN2 and ON; it is not latched.
REQ-025 stop_req SHALL be ignored in OFF, DN1 and DN2.
REQ-026 Simultaneous start_req and stop_req:
- in OFF, start wins and stop is not latched;
- in ON, stop wins.
REQ-027 seq_busy SHALL equal 1 in UP1, UP2, DN1 and DN2, and 0 in OFF and ON (decoded from the state register).
REQ-028 settle and ratio changes outside the sampling edges in REQ-015 and REQ-019 SHALL have no effect.
REQ-029 The sync counter is 4 bits wide.
- It SHALL be 0 whenever jbus_en=0.
- While jbus_en=1 it counts 0..P_reg-1 and wraps to 0.
REQ-030 jbus_sync SHALL be 1 exactly in cycles where jbus_en=1 and the sync counter equals P_reg-1; the first pulse occurs in the P-th cycle of jbus_en high.
REQ-031 jbus_sync SHALL be 0 in the cycle jbus_en falls, and the counter restarts from 0 on the next bring-up.
REQ-032 All outputs SHALL be driven from flops or from a state decode, with no combinational path from inputs to outputs.

Reset
REQ-033 grst=1 SHALL immediately force:
- state=OFF;
- cmp_en, ddr_en, jbus_en, seq_busy, seq_done and jbus_sync all 0;
- cnt, S_reg, P_reg, the sync counter and stop_pend all 0.
REQ-034 Reset asserted mid-sequence SHALL drop all enables in the same cycle, with no reverse-order shutdown.
REQ-035 After grst deasserts, the block SHALL stay in OFF until start_req is sampled 1.

Verification
REQ-036 Bring-up, settle=3, ratio=4, start_req pulsed at edge T:
- cmp_en rises at T, ddr_en at T+4, jbus_en at T+8;
- seq_done pulses at T+8;
- seq_busy is high from T through T+7;
- jbus_sync pulses at T+11, T+15, T+19, ...
REQ-037 Shutdown, settle=0, stop_req at edge U in ON:
- jbus_en falls at U, ddr_en at U+1, cmp_en at U+2;
- seq_done pulses at U+2;
- no jbus_sync at or after U.
REQ-038 Stop during bring-up, settle=2, stop_req pulsed in UP1:
- bring-up completes (jbus_en rises, seq_done pulses);
- the ON state lasts one cycle, then DN1 begins;
- enables fall 3 cycles apart.
REQ-039 Simultaneous requests: start_req=stop_req=1 in OFF leads to UP1 with stop_pend=0; the same in ON leads to DN1.
REQ-040 Reset in UP2 with cmp_en=ddr_en=1: all outputs are 0 in the same cycle; after release with start_req=0 the block stays in OFF.
REQ-041 Ratio clamp, ratio=0: jbus_sync pulses every 2nd cycle while jbus_en=1.

Source files
------------

// File: rtl/bw_clk_gclk_center_seq.sv
// Global-clock center sequencer: staged bring-up and reverse-order shutdown of the
// cmp/ddr/jbus branch enables, plus a cmp-to-jbus ratio sync pulse.
module bw_clk_gclk_center_seq (
    input  logic       gclk,
    input  logic       grst,
    input  logic       start_req,
    input  logic       stop_req,
    input  logic [3:0] settle,
    input  logic [3:0] ratio,
    output logic       cmp_en,
    output logic       ddr_en,
    output logic       jbus_en,
    output logic       seq_busy,
    output logic       seq_done,
    output logic       jbus_sync
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        ST_OFF = 3'd0,
        ST_UP1 = 3'd1,
        ST_UP2 = 3'd2,
        ST_ON  = 3'd3,
        ST_DN1 = 3'd4,
        ST_DN2 = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   s_reg, s_reg_n;
    logic [CNT_W-1:0]   p_reg, p_reg_n;
    logic [CNT_W-1:0]   sync_cnt, sync_cnt_n;
    logic               stop_pend, stop_pend_n;
    logic               cmp_en_n, ddr_en_n, jbus_en_n;
    logic               seq_busy_n, seq_done_n, jbus_sync_n;
    logic [CNT_W-1:0]   ratio_clamped;
    logic [CNT_W-1:0]   cnt_dec;

    // Periods below 2 cannot produce a distinct sync phase, so they run as 2.
    assign ratio_clamped = (ratio < CNT_W'(2)) ? CNT_W'(2) : ratio;
    assign cnt_dec       = cnt - CNT_W'(1);

    // State and all registered outputs.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state     <= ST_OFF;
            cnt       <= '0;
            s_reg     <= '0;
            p_reg     <= '0;
            sync_cnt  <= '0;
            stop_pend <= 1'b0;
            cmp_en    <= 1'b0;
            ddr_en    <= 1'b0;
            jbus_en   <= 1'b0;
            seq_busy  <= 1'b0;
            seq_done  <= 1'b0;
            jbus_sync <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            s_reg     <= s_reg_n;
            p_reg     <= p_reg_n;
            sync_cnt  <= sync_cnt_n;
            stop_pend <= stop_pend_n;
            cmp_en    <= cmp_en_n;
            ddr_en    <= ddr_en_n;
            jbus_en   <= jbus_en_n;
            seq_busy  <= seq_busy_n;
            seq_done  <= seq_done_n;
            jbus_sync <= jbus_sync_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        s_reg_n     = s_reg;
        p_reg_n     = p_reg;
        stop_pend_n = stop_pend;
        cmp_en_n    = cmp_en;
        ddr_en_n    = ddr_en;
        jbus_en_n   = jbus_en;
        seq_done_n  = 1'b0;
        sync_cnt_n  = '0;
        jbus_sync_n = 1'b0;
        seq_busy_n  = 1'b0;

        case (state)
            ST_OFF: begin
                if (start_req) begin
                    cmp_en_n = 1'b1;
                    s_reg_n  = settle;
                    p_reg_n  = ratio_clamped;
                    cnt_n    = settle;
                    state_n  = ST_UP1;
                end
            end
            ST_UP1: begin
                if (stop_req) stop_pend_n = 1'b1;
                if (cnt == '0) begin
                    ddr_en_n = 1'b1;
                    cnt_n    = s_reg;
                    state_n  = ST_UP2;
                end else begin
                    cnt_n = cnt_dec;
                end
            end
            ST_UP2: begin
                if (stop_req) stop_pend_n = 1'b1;
                if (cnt == '0) begin
                    jbus_en_n  = 1'b1;
                    seq_done_n = 1'b1;
                    state_n    = ST_ON;
                end else begin
                    cnt_n = cnt_dec;
                end
            end
            ST_ON: begin
                if (stop_req || stop_pend) begin
                    jbus_en_n   = 1'b0;
                    stop_pend_n = 1'b0;
                    s_reg_n     = settle;
                    cnt_n       = settle;
                    state_n     = ST_DN1;
                end
            end
            ST_DN1: begin
                if (cnt == '0) begin
                    ddr_en_n = 1'b0;
                    cnt_n    = s_reg;
                    state_n  = ST_DN2;
                end else begin
                    cnt_n = cnt_dec;
                end
            end
            ST_DN2: begin
                if (cnt == '0) begin
                    cmp_en_n   = 1'b0;
                    seq_done_n = 1'b1;
                    state_n    = ST_OFF;
                end else begin
                    cnt_n = cnt_dec;
                end
            end
            default: begin
                state_n = ST_OFF;
            end
        endcase

        seq_busy_n = (state_n == ST_UP1) || (state_n == ST_UP2) ||
                     (state_n == ST_DN1) || (state_n == ST_DN2);

        // Sync counter holds 0 on the first jbus cycle and while jbus is off.
        if (jbus_en_n && jbus_en) begin
            sync_cnt_n = (sync_cnt == p_reg - CNT_W'(1)) ? '0 : sync_cnt + CNT_W'(1);
        end
        jbus_sync_n = jbus_en_n && (sync_cnt_n == p_reg_n - CNT_W'(1));
    end

endmodule

// File: tb/tb_bw_clk_gclk_center_seq.sv
// Scoreboard bench: stimulus pushes hand-derived output vectors per clock edge;
// a negedge monitor pops and compares {cmp,ddr,jbus,busy,done,sync}.
module tb_bw_clk_gclk_center_seq;

    logic       gclk;
    logic       grst;
    logic       start_req;
    logic       stop_req;
    logic [3:0] settle;
    logic [3:0] ratio;
    logic       cmp_en, ddr_en, jbus_en, seq_busy, seq_done, jbus_sync;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [5:0]  exp_q[$];
    string       phase = "reset";

    // Vector encodings {cmp,ddr,jbus,busy,done,sync}
    localparam logic [5:0] V_OFF  = 6'b000000;
    localparam logic [5:0] V_C    = 6'b100100;
    localparam logic [5:0] V_CD   = 6'b110100;
    localparam logic [5:0] V_UPD  = 6'b111010;
    localparam logic [5:0] V_ON   = 6'b111000;
    localparam logic [5:0] V_SYNC = 6'b111001;
    localparam logic [5:0] V_DND  = 6'b000010;

    bw_clk_gclk_center_seq dut (
        .gclk      (gclk),
        .grst      (grst),
        .start_req (start_req),
        .stop_req  (stop_req),
        .settle    (settle),
        .ratio     (ratio),
        .cmp_en    (cmp_en),
        .ddr_en    (ddr_en),
        .jbus_en   (jbus_en),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done),
        .jbus_sync (jbus_sync)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    function automatic logic [5:0] outs();
        return {cmp_en, ddr_en, jbus_en, seq_busy, seq_done, jbus_sync};
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] e);
        n_checks++;
        if (act !== e) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, e, $time);
        end
    endtask

    // Monitor: one expected vector per edge, compared on the falling edge.
    always @(negedge gclk) begin
        if (exp_q.size() > 0) chk(phase, outs(), exp_q.pop_front());
    end

    task automatic step(input logic st, input logic sp, input logic [5:0] e);
        start_req = st;
        stop_req  = sp;
        @(posedge gclk);
        #1 exp_q.push_back(e);
        @(negedge gclk);
    endtask

    task automatic idle(input int n, input logic [5:0] e);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, e);
    endtask

    initial begin
        grst = 1'b0; start_req = 1'b0; stop_req = 1'b0;
        settle = 4'd0; ratio = 4'd0;
        #1 grst = 1'b1;
        #2 chk("reset_async", outs(), V_OFF);
        @(negedge gclk);
        step(1'b1, 1'b0, V_OFF);               // start ignored under reset
        grst = 1'b0;
        phase = "post_reset_idle";
        step(1'b0, 1'b1, V_OFF);               // stop ignored in OFF
        idle(2, V_OFF);

        // Bring-up settle=3 ratio=4; settle/ratio changes mid-sequence are ignored.
        phase = "bringup_s3_p4";
        settle = 4'd3; ratio = 4'd4;
        step(1'b1, 1'b0, V_C);                 // T
        settle = 4'd9; ratio = 4'd7;
        idle(3, V_C);                          // T+1..T+3
        idle(4, V_CD);                         // T+4..T+7
        step(1'b1, 1'b0, V_UPD);               // T+8, start ignored in UP2
        step(1'b1, 1'b0, V_ON);                // T+9, start ignored in ON
        idle(1, V_ON);
        step(1'b0, 1'b0, V_SYNC);              // T+11
        idle(3, V_ON);
        step(1'b0, 1'b0, V_SYNC);              // T+15
        idle(3, V_ON);
        step(1'b0, 1'b0, V_SYNC);              // T+19

        // Shutdown settle=0 with simultaneous start: stop wins in ON.
        phase = "shutdown_s0";
        settle = 4'd0;
        step(1'b1, 1'b1, V_CD);                // U
        idle(1, V_C);                          // U+1
        idle(1, V_DND);                        // U+2
        step(1'b0, 1'b1, V_OFF);
        idle(2, V_OFF);

        // Stop during bring-up with settle=2: ON lasts one cycle, falls 3 apart.
        phase = "stop_in_up1";
        settle = 4'd2; ratio = 4'd3;
        step(1'b1, 1'b0, V_C);                 // T
        step(1'b0, 1'b1, V_C);                 // T+1 stop in UP1
        idle(1, V_C);
        idle(3, V_CD);                         // T+3..T+5
        idle(1, V_UPD);                        // T+6 ON
        idle(3, V_CD);                         // T+7..T+9 jbus fell
        idle(3, V_C);                          // T+10..T+12
        idle(1, V_DND);                        // T+13
        idle(2, V_OFF);

        // Simultaneous requests in OFF, ratio=0 clamp: sync every 2nd cycle.
        phase = "simul_off_ratio0";
        settle = 4'd0; ratio = 4'd0;
        step(1'b1, 1'b1, V_C);
        idle(1, V_CD);
        idle(1, V_UPD);
        for (int i = 0; i < 3; i++) begin
            idle(1, V_SYNC);
            idle(1, V_ON);
        end

        // Shutdown, then reset mid-UP2.
        phase = "reset_in_up2";
        step(1'b0, 1'b1, V_CD);
        idle(1, V_C);
        idle(1, V_DND);
        settle = 4'd5;
        step(1'b1, 1'b0, V_C);
        idle(5, V_C);
        idle(2, V_CD);                         // now in UP2
        #2 grst = 1'b1;
        #1 chk("reset_mid_up2", outs(), V_OFF);
        step(1'b0, 1'b0, V_OFF);
        grst = 1'b0;
        phase = "after_reset_idle";
        idle(4, V_OFF);

        // Recovery bring-up after reset.
        phase = "recover_s0_p2";
        settle = 4'd0; ratio = 4'd2;
        step(1'b1, 1'b0, V_C);
        idle(1, V_CD);
        idle(1, V_UPD);
        idle(1, V_SYNC);

        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
